// File: rtl/audio_pkg.sv
// Field layout of packed note commands and the sequencer state encoding.
package audio_pkg;

  localparam int HALF_W   = 18;
  localparam int DUR_W    = 14;
  localparam int VOL_W    = 10;
  localparam int CMD_W    = 32;
  localparam int HALF_LSB = 14;
  localparam int DUR_LSB  = 0;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} seq_state_t;

  function automatic logic [HALF_W-1:0] cmd_half(input logic [CMD_W-1:0] cmd);
    return cmd[HALF_LSB +: HALF_W];
  endfunction

  function automatic logic [DUR_W-1:0] cmd_dur(input logic [CMD_W-1:0] cmd);
    return cmd[DUR_LSB +: DUR_W];
  endfunction

endpackage

// File: rtl/note_fifo.sv
// Synchronous command FIFO; read data is registered and valid the cycle after a pop.
module note_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        wr_data,
  output logic [WIDTH-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !flush;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        rd_data <= mem[rd_ptr];
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_ONE;
      end else if (do_pop && !do_push) begin
        count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Plays queued note commands in order as a square wave on the PWM duty output.
module note_sequencer
  import audio_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [CMD_W-1:0]             wr_data,
  input  logic [VOL_W-1:0]             volume,
  input  logic                         flush,
  output logic [VOL_W-1:0]             duty_cycle,
  output logic                         busy,
  output logic                         note_done,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  seq_state_t        state, state_next;
  logic [HALF_W-1:0] half_q, half_next;
  logic [HALF_W-1:0] hcnt_q, hcnt_next;
  logic [DUR_W-1:0]  rem_q, rem_next;
  logic [PRE_W-1:0]  pre_q, pre_next;
  logic              phase_q, phase_next;
  logic [VOL_W-1:0]  vol_q, vol_next;
  logic [VOL_W-1:0]  duty_next;
  logic              busy_next;
  logic              done_next;
  logic              ovf_next;
  logic              pop;
  logic              tick_wrap;
  logic [CMD_W-1:0]  head;
  logic [HALF_W-1:0] head_half;
  logic [DUR_W-1:0]  head_dur;

  note_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (wr_en),
    .pop     (pop),
    .flush   (flush),
    .wr_data (wr_data),
    .rd_data (head),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

  assign head_half = cmd_half(head);
  assign head_dur  = cmd_dur(head);
  assign tick_wrap = (pre_q == PRE_MAX);

  always_comb begin
    state_next = state;
    half_next  = half_q;
    hcnt_next  = hcnt_q;
    rem_next   = rem_q;
    pre_next   = pre_q;
    phase_next = phase_q;
    vol_next   = vol_q;
    duty_next  = '0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    ovf_next   = overflow;
    pop        = 1'b0;
    if (flush) begin
      state_next = IDLE;
      ovf_next   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = LOAD;
          end
        end
        LOAD: begin
          half_next = head_half;
          rem_next  = head_dur;
          vol_next  = volume;
          if (head_dur == '0) begin
            state_next = IDLE;
          end else begin
            pre_next   = '0;
            hcnt_next  = '0;
            phase_next = (head_half != '0);
            duty_next  = (head_half != '0) ? volume : '0;
            busy_next  = 1'b1;
            state_next = PLAY;
          end
        end
        PLAY: begin
          busy_next = 1'b1;
          pre_next  = tick_wrap ? '0 : pre_q + PRE_W'(1);
          // A zero half-period is a rest: the output stays silent for the whole note.
          if (half_q != '0) begin
            if (hcnt_q == half_q - HALF_W'(1)) begin
              hcnt_next  = '0;
              phase_next = ~phase_q;
            end else begin
              hcnt_next = hcnt_q + HALF_W'(1);
            end
          end else begin
            phase_next = 1'b0;
          end
          duty_next = phase_next ? vol_q : '0;
          if (tick_wrap) begin
            rem_next = rem_q - DUR_W'(1);
            if (rem_q == DUR_W'(1)) begin
              state_next = IDLE;
              done_next  = 1'b1;
              busy_next  = 1'b0;
              duty_next  = '0;
            end
          end
        end
        default: state_next = IDLE;
      endcase
      if (wr_en && full && !pop) begin
        ovf_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      half_q     <= '0;
      hcnt_q     <= '0;
      rem_q      <= '0;
      pre_q      <= '0;
      phase_q    <= 1'b0;
      vol_q      <= '0;
      duty_cycle <= '0;
      busy       <= 1'b0;
      note_done  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_next;
      half_q     <= half_next;
      hcnt_q     <= hcnt_next;
      rem_q      <= rem_next;
      pre_q      <= pre_next;
      phase_q    <= phase_next;
      vol_q      <= vol_next;
      duty_cycle <= duty_next;
      busy       <= busy_next;
      note_done  <= done_next;
      overflow   <= ovf_next;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer against a timeline-based reference model.
module tb_note_sequencer;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DEPTH   = 4;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_PLAY  = 2;
  localparam logic [17:0] RESET_VEC = {10'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] wr_data = '0;
  logic [9:0]  volume = '0;
  logic [9:0]  duty_cycle;
  logic        busy;
  logic        note_done;
  logic [2:0]  fifo_count;
  logic        full;
  logic        empty;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mq[$];
  int          m_mode;
  int          m_t;
  logic [31:0] m_cur;
  logic [9:0]  m_vol;
  bit          m_ovf;
  bit          m_done;

  always #5 clock = ~clock;

  note_sequencer #(
    .CLK_HZ     (CLK_HZ),
    .TICK_HZ    (TICK_HZ),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .volume     (volume),
    .flush      (flush),
    .duty_cycle (duty_cycle),
    .busy       (busy),
    .note_done  (note_done),
    .fifo_count (fifo_count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
  );

  function automatic logic [31:0] mk(input int h, input int d);
    return {18'(h), 14'(d)};
  endfunction

  function automatic logic [17:0] obs();
    return {duty_cycle, busy, note_done, fifo_count, full, empty, overflow};
  endfunction

  // Expected outputs: the waveform is derived from elapsed play time, not counters.
  function automatic logic [17:0] expv();
    int h;
    logic [9:0] d;
    d = '0;
    h = int'(m_cur[31:14]);
    if (m_mode == M_PLAY && h != 0 && ((m_t / h) % 2) == 0) d = m_vol;
    return {d, (m_mode == M_PLAY), m_done, 3'(mq.size()),
            (mq.size() == DEPTH), (mq.size() == 0), m_ovf};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_mode = M_IDLE;
    m_t    = 0;
    m_cur  = '0;
    m_vol  = '0;
    m_ovf  = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic model_step(input bit wr, input logic [31:0] d, input logic [9:0] v, input bit fl);
    m_done = 1'b0;
    if (fl) begin
      mq.delete();
      m_mode = M_IDLE;
      m_ovf  = 1'b0;
      return;
    end
    case (m_mode)
      M_IDLE: if (mq.size() > 0) begin
        m_cur  = mq.pop_front();
        m_mode = M_LOAD;
      end
      M_LOAD: begin
        m_vol = v;
        if (m_cur[13:0] == 14'd0) m_mode = M_IDLE;
        else begin
          m_mode = M_PLAY;
          m_t    = 0;
        end
      end
      default: begin
        m_t++;
        if (m_t == int'(m_cur[13:0]) * DIV) begin
          m_mode = M_IDLE;
          m_done = 1'b1;
        end
      end
    endcase
    if (wr) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic step(input bit wr, input logic [31:0] d, input logic [9:0] v, input bit fl);
    wr_en   = wr;
    wr_data = d;
    volume  = v;
    flush   = fl;
    model_step(wr, d, v, fl);
    @(posedge clock);
    #1;
    wr_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (obs() !== RESET_VEC) begin
      n_fail++;
      $display("[TB] FAIL reset_vals: got %h want %h", obs(), RESET_VEC);
    end
    @(negedge clock) reset = 1'b0;
    step(0, '0, '0, 0);
    n_checks++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("[TB] FAIL reset_idle: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_single_note();
    int busy_cnt = 0, high_cnt = 0, done_cnt = 0, first_busy = -1;
    step(1, mk(3, 2), 10'd512, 0);
    n_checks++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("[TB] FAIL single_write: got %h want %h", obs(), expv());
    end
    for (int i = 1; i <= 25; i++) begin
      step(0, '0, 10'd512, 0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("[TB] FAIL single_cyc%0d: got %h want %h", i, obs(), expv());
      end
      if (busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = i;
      end
      if (duty_cycle == 10'd512) high_cnt++;
      if (note_done) done_cnt++;
    end
    n_checks++;
    if (first_busy !== 2) begin
      n_fail++;
      $display("[TB] FAIL single_latency: got %0d want 2", first_busy);
    end
    n_checks++;
    if (busy_cnt !== 20) begin
      n_fail++;
      $display("[TB] FAIL single_length: got %0d want 20", busy_cnt);
    end
    n_checks++;
    if (high_cnt !== 11) begin
      n_fail++;
      $display("[TB] FAIL single_high: got %0d want 11", high_cnt);
    end
    n_checks++;
    if (done_cnt !== 1) begin
      n_fail++;
      $display("[TB] FAIL single_done: got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_rest_zero();
    int busy_cnt = 0, loud_cnt = 0, done_cnt = 0;
    logic [9:0] v;
    v = 10'($urandom_range(1, 1023));
    for (int i = 0; i < 24; i++) begin
      if (i == 0) step(1, mk(0, 1), v, 0);
      else if (i == 1) step(1, mk(5, 0), v, 0);
      else step(0, '0, v, 0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("[TB] FAIL rest_cyc%0d: got %h want %h", i, obs(), expv());
      end
      if (busy) busy_cnt++;
      if (duty_cycle != '0) loud_cnt++;
      if (note_done) done_cnt++;
    end
    n_checks++;
    if ({busy_cnt, loud_cnt, done_cnt} !== {32'd10, 32'd0, 32'd1}) begin
      n_fail++;
      $display("[TB] FAIL rest_summary: got busy=%0d loud=%0d done=%0d want 10 0 1",
               busy_cnt, loud_cnt, done_cnt);
    end
  endtask

  task automatic test_overflow();
    int done_cnt = 0;
    logic [9:0] v;
    v = 10'($urandom_range(1, 1023));
    for (int k = 0; k < 6; k++) begin
      step(1, mk(k + 1, 1), v, 0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("[TB] FAIL ovf_write%0d: got %h want %h", k, obs(), expv());
      end
    end
    n_checks++;
    if ({fifo_count, full, overflow} !== {3'd4, 1'b1, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL ovf_status: got cnt=%0d full=%b ovf=%b want 4 1 1",
               fifo_count, full, overflow);
    end
    for (int i = 0; i < 90; i++) begin
      step(0, '0, v, 0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("[TB] FAIL ovf_play%0d: got %h want %h", i, obs(), expv());
      end
      if (note_done) done_cnt++;
    end
    n_checks++;
    if (done_cnt !== 5) begin
      n_fail++;
      $display("[TB] FAIL ovf_notes: got %0d want 5", done_cnt);
    end
  endtask

  task automatic test_flush();
    logic [9:0] v;
    v = 10'($urandom_range(1, 1023));
    for (int i = 0; i < 9; i++) begin
      step(i < 6, mk(2, 3), v, 0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("[TB] FAIL flush_pre%0d: got %h want %h", i, obs(), expv());
      end
    end
    step(1, mk(4, 4), v, 1);
    n_checks++;
    if (obs() !== RESET_VEC) begin
      n_fail++;
      $display("[TB] FAIL flush_clear: got %h want %h", obs(), RESET_VEC);
    end
    for (int i = 0; i < 15; i++) begin
      step(0, '0, v, 0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("[TB] FAIL flush_post%0d: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    int busy_cnt = 0, done_cnt = 0;
    logic [9:0] v;
    v = 10'($urandom_range(1, 1023));
    step(1, mk(3, 2), v, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, '0, v, 0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("[TB] FAIL rstmid_pre%0d: got %h want %h", i, obs(), expv());
      end
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs() !== RESET_VEC) begin
      n_fail++;
      $display("[TB] FAIL rstmid_async: got %h want %h", obs(), RESET_VEC);
    end
    model_reset();
    #2 reset = 1'b0;
    step(1, mk(3, 2), v, 0);
    for (int i = 0; i < 25; i++) begin
      step(0, '0, v, 0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("[TB] FAIL rstmid_post%0d: got %h want %h", i, obs(), expv());
      end
      if (busy) busy_cnt++;
      if (note_done) done_cnt++;
    end
    n_checks++;
    if (busy_cnt !== 20 || done_cnt !== 1) begin
      n_fail++;
      $display("[TB] FAIL rstmid_replay: got busy=%0d done=%0d want 20 1", busy_cnt, done_cnt);
    end
  endtask

  task automatic test_full_pushpop();
    int guard = 0;
    logic [9:0] v;
    v = 10'($urandom_range(1, 1023));
    step(0, '0, v, 1);
    for (int k = 0; k < 5; k++) begin
      step(1, mk(k + 1, 1), v, 0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("[TB] FAIL fullpp_fill%0d: got %h want %h", k, obs(), expv());
      end
    end
    n_checks++;
    if ({fifo_count, full, overflow} !== {3'd4, 1'b1, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL fullpp_full: got cnt=%0d full=%b ovf=%b want 4 1 0",
               fifo_count, full, overflow);
    end
    while (note_done !== 1'b1 && guard < 40) begin
      step(0, '0, v, 0);
      guard++;
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("[TB] FAIL fullpp_wait%0d: got %h want %h", guard, obs(), expv());
      end
    end
    n_checks++;
    if (guard >= 40) begin
      n_fail++;
      $display("[TB] FAIL fullpp_timeout: got no note_done in %0d cycles want one", guard);
    end
    step(1, mk(7, 1), v, 0);
    n_checks++;
    if ({fifo_count, full, overflow} !== {3'd4, 1'b1, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL fullpp_pushpop: got cnt=%0d full=%b ovf=%b want 4 1 0",
               fifo_count, full, overflow);
    end
    for (int i = 0; i < 80; i++) begin
      step(0, '0, v, 0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("[TB] FAIL fullpp_drain%0d: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    bit wr, fl;
    logic [31:0] d;
    for (int i = 0; i < 600; i++) begin
      wr = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 79) == 0);
      d  = mk($urandom_range(0, 4), $urandom_range(0, 2));
      step(wr, d, 10'($urandom), fl);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("[TB] FAIL random_cyc%0d: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_note();
    test_rest_zero();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_full_pushpop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
